// File: rtl/sram_cim_ctrl_pkg.sv
// rtl/sram_cim_ctrl_pkg.sv - op encodings, FSM states and default timing for the SRAM_CIM sequencer
package sram_cim_ctrl_pkg;

  localparam logic [1:0] OP_WR_ARR = 2'b00;
  localparam logic [1:0] OP_WR_BUF = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_COMP   = 2'b11;

  localparam int unsigned DEF_WR_CYCLES  = 21;
  localparam int unsigned DEF_RD_CYCLES  = 3;
  localparam int unsigned DEF_SET_CYCLES = 2;
  localparam int unsigned DEF_BIT_CYCLES = 2;
  localparam int unsigned DEF_REL_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_SET,
    ST_PRE,
    ST_BIT,
    ST_REL,
    ST_FIN
  } state_t;

endpackage

// File: rtl/cim_ctrl_timer.sv
// rtl/cim_ctrl_timer.sv - 8-bit loadable down-counter; o_expire is high during the last cycle of a loaded duration
module cim_ctrl_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_value,
  output logic       o_expire
);

  logic [7:0] r_count;
  logic       r_expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 8'd0;
      r_expire <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_value - 8'd1;
      r_expire <= (i_value == 8'd1);
    end else if (r_count != 8'd0) begin
      r_count  <= r_count - 8'd1;
      r_expire <= (r_count == 8'd1);
    end else begin
      r_expire <= 1'b0;
    end
  end

  assign o_expire = r_expire;

endmodule

// File: rtl/sram_cim_ctrl.sv
// rtl/sram_cim_ctrl.sv - command sequencer driving SRAM_CIM macro pins with fixed cycle timing
module sram_cim_ctrl
  import sram_cim_ctrl_pkg::*;
#(
  parameter int unsigned WR_CYCLES  = DEF_WR_CYCLES,
  parameter int unsigned RD_CYCLES  = DEF_RD_CYCLES,
  parameter int unsigned SET_CYCLES = DEF_SET_CYCLES,
  parameter int unsigned BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int unsigned REL_CYCLES = DEF_REL_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [8:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        done,
  output logic        busy,
  output logic [8:0]  cim_a,
  output logic [15:0] cim_d,
  input  logic [15:0] cim_q,
  output logic        cim_wrt,
  output logic        cim_wrtbuf,
  output logic        cim_read,
  output logic        cim_set,
  output logic        cim_comp,
  output logic        cim_model,
  output logic        cim_inbit,
  output logic        cim_wait_
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_phase;
  logic        w_phase_next;
  logic [1:0]  r_op;
  logic [1:0]  w_op_eff;
  logic        w_accept;
  logic        w_load;
  logic [7:0]  w_dur;
  logic        w_expire;
  logic        w_in_phase;

  logic        r_cmd_ready, r_rsp_valid, r_done, r_busy;
  logic [15:0] r_rsp_data;
  logic [8:0]  r_cim_a;
  logic [15:0] r_cim_d;
  logic        r_wrt, r_wrtbuf, r_read, r_set, r_comp, r_model, r_inbit, r_wait;

  cim_ctrl_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_value  (w_dur),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_accept     = cmd_valid && r_cmd_ready && (r_state == ST_IDLE);
    w_op_eff     = w_accept ? cmd_op : r_op;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_WR_ARR, OP_WR_BUF: w_state_next = ST_WRITE;
            OP_READ:              w_state_next = ST_READ;
            default: begin
              w_state_next = ST_SET;
              w_phase_next = 1'b0;
            end
          endcase
        end
      end
      ST_WRITE, ST_READ: if (w_expire) w_state_next = ST_FIN;
      ST_SET:            if (w_expire) w_state_next = ST_PRE;
      ST_PRE:            if (w_expire) w_state_next = ST_BIT;
      ST_BIT:            if (w_expire) w_state_next = ST_REL;
      ST_REL: begin
        if (w_expire) begin
          if (r_phase) begin
            w_state_next = ST_FIN;
          end else begin
            w_state_next = ST_PRE;
            w_phase_next = 1'b1;
          end
        end
      end
      ST_FIN:            if (w_expire) w_state_next = ST_IDLE;
      default:           w_state_next = ST_IDLE;
    endcase

    // Every state entry reloads the timer with that state's duration; IDLE needs no timing.
    w_load = (w_state_next != r_state) && (w_state_next != ST_IDLE);
    case (w_state_next)
      ST_WRITE: w_dur = 8'(WR_CYCLES);
      ST_READ:  w_dur = 8'(RD_CYCLES);
      ST_SET:   w_dur = 8'(SET_CYCLES);
      ST_BIT:   w_dur = 8'(BIT_CYCLES);
      ST_REL:   w_dur = 8'(REL_CYCLES);
      default:  w_dur = 8'd1;
    endcase
    w_in_phase = (w_state_next == ST_PRE) || (w_state_next == ST_BIT) || (w_state_next == ST_REL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_phase     <= 1'b0;
      r_op        <= 2'b00;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'd0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cim_a     <= 9'd0;
      r_cim_d     <= 16'd0;
      r_wrt       <= 1'b0;
      r_wrtbuf    <= 1'b0;
      r_read      <= 1'b0;
      r_set       <= 1'b0;
      r_comp      <= 1'b0;
      r_model     <= 1'b0;
      r_inbit     <= 1'b0;
      r_wait      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      if (w_accept) begin
        r_op    <= cmd_op;
        r_cim_a <= cmd_addr;
        r_cim_d <= cmd_data;
      end
      r_cmd_ready <= (w_state_next == ST_IDLE);
      r_busy      <= (w_state_next != ST_IDLE);
      r_done      <= (w_state_next == ST_FIN);
      r_rsp_valid <= (r_state == ST_READ) && w_expire;
      if ((r_state == ST_READ) && w_expire) r_rsp_data <= cim_q;
      r_wrt    <= (w_state_next == ST_WRITE) && (w_op_eff == OP_WR_ARR);
      r_wrtbuf <= (w_state_next == ST_WRITE) && (w_op_eff == OP_WR_BUF);
      r_read   <= (w_state_next == ST_READ);
      r_set    <= (w_state_next == ST_SET);
      r_comp   <= w_in_phase;
      r_model  <= w_in_phase && w_phase_next;
      r_inbit  <= (w_state_next == ST_BIT);
      r_wait   <= (w_state_next == ST_PRE) || (w_state_next == ST_BIT);
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign done       = r_done;
  assign busy       = r_busy;
  assign cim_a      = r_cim_a;
  assign cim_d      = r_cim_d;
  assign cim_wrt    = r_wrt;
  assign cim_wrtbuf = r_wrtbuf;
  assign cim_read   = r_read;
  assign cim_set    = r_set;
  assign cim_comp   = r_comp;
  assign cim_model  = r_model;
  assign cim_inbit  = r_inbit;
  assign cim_wait_  = r_wait;

endmodule

// File: tb/tb_sram_cim_ctrl.sv
// tb/tb_sram_cim_ctrl.sv - self-checking bench for sram_cim_ctrl against a per-cycle schedule model
module tb_sram_cim_ctrl;

  localparam int WR_C  = 21;
  localparam int RD_C  = 3;
  localparam int SET_C = 2;
  localparam int BIT_C = 2;
  localparam int REL_C = 2;

  localparam logic [11:0] B_WRT   = 12'h800;
  localparam logic [11:0] B_WBUF  = 12'h400;
  localparam logic [11:0] B_READ  = 12'h200;
  localparam logic [11:0] B_SET   = 12'h100;
  localparam logic [11:0] B_COMP  = 12'h080;
  localparam logic [11:0] B_MODEL = 12'h040;
  localparam logic [11:0] B_INBIT = 12'h020;
  localparam logic [11:0] B_WAIT  = 12'h010;
  localparam logic [11:0] B_RSPV  = 12'h008;
  localparam logic [11:0] B_DONE  = 12'h004;
  localparam logic [11:0] B_BUSY  = 12'h002;
  localparam logic [11:0] B_READY = 12'h001;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        rsp_valid, done, busy;
  logic [15:0] rsp_data;
  logic [8:0]  cim_a;
  logic [15:0] cim_d, cim_q;
  logic        cim_wrt, cim_wrtbuf, cim_read, cim_set, cim_comp, cim_model, cim_inbit, cim_wait_;

  int checks;
  int failures;
  logic [11:0] sched[$];

  sram_cim_ctrl #(
    .WR_CYCLES(WR_C), .RD_CYCLES(RD_C), .SET_CYCLES(SET_C),
    .BIT_CYCLES(BIT_C), .REL_CYCLES(REL_C)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .busy(busy),
    .cim_a(cim_a), .cim_d(cim_d), .cim_q(cim_q),
    .cim_wrt(cim_wrt), .cim_wrtbuf(cim_wrtbuf), .cim_read(cim_read),
    .cim_set(cim_set), .cim_comp(cim_comp), .cim_model(cim_model),
    .cim_inbit(cim_inbit), .cim_wait_(cim_wait_)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] obs_vec();
    return {cim_wrt, cim_wrtbuf, cim_read, cim_set, cim_comp, cim_model,
            cim_inbit, cim_wait_, rsp_valid, done, busy, cmd_ready};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pin vector for each cycle T+1.. after an accept, built from the op's phase list.
  task automatic build_sched(input logic [1:0] op);
    sched.delete();
    case (op)
      2'b00: repeat (WR_C) sched.push_back(B_WRT | B_BUSY);
      2'b01: repeat (WR_C) sched.push_back(B_WBUF | B_BUSY);
      2'b10: repeat (RD_C) sched.push_back(B_READ | B_BUSY);
      default: begin
        repeat (SET_C) sched.push_back(B_SET | B_BUSY);
        for (int p = 0; p < 2; p++) begin
          logic [11:0] m;
          m = (p == 1) ? B_MODEL : 12'h000;
          sched.push_back(B_COMP | m | B_WAIT | B_BUSY);
          repeat (BIT_C) sched.push_back(B_COMP | m | B_INBIT | B_WAIT | B_BUSY);
          repeat (REL_C) sched.push_back(B_COMP | m | B_BUSY);
        end
      end
    endcase
    sched.push_back(B_DONE | B_BUSY | ((op == 2'b10) ? B_RSPV : 12'h000));
    sched.push_back(B_READY);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [8:0] addr, input logic [15:0] data,
                        input logic [15:0] q, input bit hold, input int abort_k);
    build_sched(op);
    chk($sformatf("ready_before_op%0d", op), cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cim_q     = q;
    @(posedge clk);
    for (int k = 1; k <= sched.size(); k++) begin
      @(negedge clk);
      chk($sformatf("op%0d_cyc%0d", op, k), obs_vec(), sched[k-1]);
      if (k == 1) begin
        chk($sformatf("op%0d_addr", op), cim_a, addr);
        chk($sformatf("op%0d_data", op), cim_d, data);
        if (!hold) cmd_valid = 1'b0;
      end
      if (sched[k-1][3]) chk("rsp_data", rsp_data, q);
      if (hold && k == sched.size() - 1) cmd_valid = 1'b0;
      if (k == abort_k) begin
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", obs_vec(), B_READY);
        @(negedge clk);
        chk("abort_no_done", obs_vec(), B_READY);
        return;
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 9'd0;
    cmd_data  = 16'd0;
    cim_q     = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_vec", obs_vec(), B_READY);
    chk("reset_a", cim_a, 0);
    chk("reset_d", cim_d, 0);
    chk("reset_rsp", rsp_data, 0);
    @(negedge clk);
    chk("idle_vec", obs_vec(), B_READY);

    run_op(2'b00, 9'd250, 16'd65535, 16'h0000, 1'b0, 0);
    run_op(2'b01, 9'd511, 16'd65535, 16'h0000, 1'b0, 0);
    run_op(2'b01, 9'd2,   16'd12341, 16'h0000, 1'b0, 0);
    run_op(2'b10, 9'd12,  16'd0,     16'd65532, 1'b0, 0);
    run_op(2'b11, 9'd7,   16'h1234,  16'h0000, 1'b1, 0);
    run_op(2'b11, 9'd33,  16'h00ff,  16'h0000, 1'b0, 9);
    run_op(2'b00, 9'd100, 16'hbeef,  16'h0000, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      run_op(2'($urandom_range(0, 3)), 9'($urandom), 16'($urandom), 16'($urandom), 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
